ahb_lite_slave_regbank: RTL
===========================

Name: ahb_lite_slave_regbank

Overview:
- Parametrised AHB-Lite slave for the USB endpoint subsystem. Terminates bus transfers into three regions:
  - read-only status words;
  - read/write control words with byte-lane writes;
  - a FIFO data window that pops the RX buffer on read and pushes the TX buffer on write.
- Adds pipelined back-to-back transfers, wait states on FIFO empty/full, and the two-cycle AHB ERROR response.

Parameters:
- ADDR_W, 8, haddr width in bits.
- DATA_W, 32, bus data width; must be 32 or 64.
- NUM_STAT, 4, number of read-only status words.
- NUM_CTRL, 4, number of read/write control words.
- MAX_WAIT, 8, wait-state limit before timeout; used only when the timeout feature is compiled in.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset.
- hsel  in  1  slave select.
- haddr  in  ADDR_W  byte address.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hsize  in  3  transfer size, log2 of bytes.
- hwrite  in  1  1 = write.
- hwdata  in  DATA_W  write data, valid in the data phase.
- hrdata  out  DATA_W  read data.
- hready  out  1  transfer done / slave ready.
- hresp  out  1  1 = ERROR.
- stat_in  in  NUM_STAT*DATA_W  status words; word k is at bits [k*DATA_W +: DATA_W].
- ctrl_out  out  NUM_CTRL*DATA_W  control register contents.
- rx_data  in  DATA_W  RX FIFO head.
- rx_empty  in  1  RX FIFO empty.
- rx_pop  out  1  one-cycle pop strobe.
- tx_wdata  out  DATA_W  TX push data.
- tx_full  in  1  TX FIFO full.
- tx_push  out  1  one-cycle push strobe.

Interface decision (fixed): one clock, clk; reset n_rst is asynchronous and active-low.

Behaviour:
- Reset values: hready=1, hresp=0, hrdata=0, ctrl_out=0, rx_pop=0, tx_push=0, tx_wdata=0; state IDLE. Reset mid-transfer abandons the transfer with no FIFO strobe.
- Address phase is accepted when hsel=1, htrans[1]=1 and hready=1. On acceptance, register haddr, hwrite, hsize and the decode result. BUSY and IDLE transfers get a zero-wait OKAY response.
- Decode:
  - word index = haddr >> log2(DATA_W/8).
  - Index 0..NUM_STAT-1: STATUS region.
  - Next NUM_CTRL indices: CTRL region.
  - Index NUM_STAT+NUM_CTRL: DATA region.
  - Any other index: unmapped.
- Error conditions, all giving an ERROR response:
  - unmapped address;
  - write to STATUS;
  - hsize > log2(DATA_W/8);
  - address misaligned to hsize;
  - DATA access not full-width.
- States: IDLE, DATA, WAIT, ERR1, ERR2.
  - IDLE: accepted good access goes to DATA; accepted bad access goes to ERR1.
  - DATA, STATUS/CTRL regions: single-cycle OKAY (hready=1, hresp=0). A new address phase is accepted in the same cycle, so back-to-back transfers have zero bubbles. Next state follows the new address phase, or IDLE if none.
  - DATA, DATA region:
    - read with rx_empty=0: rx_pop=1 and hrdata=rx_data, completing that cycle;
    - write with tx_full=0: tx_push=1 and tx_wdata=hwdata, completing that cycle;
    - otherwise hready=0 and go to WAIT.
  - WAIT: hready=0 each cycle until the FIFO condition clears, then complete exactly as in DATA. Exactly one pop or push per transfer.
  - ERR1: hresp=1, hready=0.
  - ERR2: hresp=1, hready=1. Return to IDLE; an address phase presented during ERR2 is accepted.
- CTRL writes: byte lanes are enabled from haddr low bits and hsize. Only enabled lanes of the selected word update from hwdata at the end of the data phase.
- CTRL/STATUS reads: hrdata is driven from the selected word during the data phase. hrdata=0 on errors, writes and idle.
- Simultaneous CTRL write then immediate read of the same word: the read returns the new value.

Optional Feature:
- Macro AHB_USB_RD_TIMEOUT_EN.
- Defined: a wait counter runs in WAIT. When it reaches MAX_WAIT cycles with the FIFO still blocked, go to ERR1 with no pop or push.
- Undefined: WAIT holds indefinitely and MAX_WAIT is ignored.

Decomposition:
- Package ahb_usb_pkg holds:
  - state_t enum (IDLE, DATA, WAIT, ERR1, ERR2);
  - region_t enum (STATUS, CTRL, DATA, BAD);
  - HTRANS_* and HSIZE_* constants.
- One combinational sub-module, ahb_usb_addr_decode: inputs haddr, hsize, hwrite; outputs region, word index, byte-lane mask and error flag.

Test Plan:
- After reset, write 0xA5A5A5A5 word to CTRL index NUM_STAT (byte address 0x10) -> OKAY, zero wait, ctrl_out word0=0xA5A5A5A5. Then a byte write of 0x3C at 0x11 -> word0=0xA5A53CA5.
- Back-to-back NONSEQ reads of STATUS0 and STATUS1 with stat_in=0x11,0x22 -> hrdata 0x11 then 0x22 on consecutive cycles, hready stays 1.
- Read DATA window (0x20) with rx_empty=1 for 3 cycles, then rx_data=0xDEAD -> hready=0 for 3 cycles, then exactly one rx_pop with hrdata=0xDEAD.
- Write to STATUS (0x04) and read of unmapped 0xFC -> each gives ERR1 (hresp=1, hready=0) then ERR2 (hresp=1, hready=1). No ctrl change, no strobes.
- With the macro defined and tx_full held at 1, write to DATA -> MAX_WAIT=8 wait cycles, then two-cycle ERROR, tx_push never asserted. Without the macro, push occurs when tx_full drops.
- Assert n_rst during WAIT -> all outputs take reset values immediately; next transfer completes normally.

Source files
------------

// File: rtl/ahb_usb_pkg.sv
// Shared types and AHB-Lite encodings for the USB endpoint register bank.
// Optional timeout build: define AHB_USB_RD_TIMEOUT_EN.
package ahb_usb_pkg;

    // Enumerator labels carry prefixes because state_t and region_t share one scope.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    typedef enum logic [1:0] {
        REG_STATUS,
        REG_CTRL,
        REG_DATA,
        REG_BAD
    } region_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

endpackage

// File: rtl/ahb_usb_addr_decode.sv
// Combinational address-phase decode: region, word index, byte lanes and
// the error flag for every illegal access.
module ahb_usb_addr_decode
    import ahb_usb_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int NUM_STAT = 4,
    parameter int NUM_CTRL = 4
)(
    input  logic [ADDR_W-1:0]   haddr,
    input  logic [2:0]          hsize,
    input  logic                hwrite,
    output region_t             region,
    output logic [ADDR_W-1:0]   word_idx,
    output logic [DATA_W/8-1:0] lane_mask,
    output logic                err
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    logic [7:0] lo;
    logic       misaligned;
    int         off;
    int         nbytes;

    always_comb begin
        word_idx = haddr >> OFF_W;

        if (word_idx < ADDR_W'(NUM_STAT))
            region = REG_STATUS;
        else if (word_idx < ADDR_W'(NUM_STAT + NUM_CTRL))
            region = REG_CTRL;
        else if (word_idx == ADDR_W'(NUM_STAT + NUM_CTRL))
            region = REG_DATA;
        else
            region = REG_BAD;

        // Low address bits below the transfer size must be zero.
        lo         = 8'(haddr);
        misaligned = |(lo & ((8'd1 << hsize) - 8'd1));

        off       = int'(lo) % BYTES;
        nbytes    = 1 << hsize;
        lane_mask = '0;
        for (int b = 0; b < BYTES; b++)
            lane_mask[b] = (b >= off) && (b < off + nbytes);

        err = (region == REG_BAD)
           || (region == REG_STATUS && hwrite)
           || (hsize > 3'(OFF_W))
           || misaligned
           || (region == REG_DATA && hsize != 3'(OFF_W));
    end

endmodule

// File: rtl/ahb_lite_slave_regbank.sv
// AHB-Lite slave: status words, byte-writable control words and an RX/TX FIFO window.
// Define AHB_USB_RD_TIMEOUT_EN to abort FIFO waits with ERROR after MAX_WAIT stalled cycles.
module ahb_lite_slave_regbank
    import ahb_usb_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int NUM_STAT = 4,
    parameter int NUM_CTRL = 4,
    parameter int MAX_WAIT = 8
)(
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         hsel,
    input  logic [ADDR_W-1:0]            haddr,
    input  logic [1:0]                   htrans,
    input  logic [2:0]                   hsize,
    input  logic                         hwrite,
    input  logic [DATA_W-1:0]            hwdata,
    output logic [DATA_W-1:0]            hrdata,
    output logic                         hready,
    output logic                         hresp,
    input  logic [NUM_STAT*DATA_W-1:0]   stat_in,
    output logic [NUM_CTRL*DATA_W-1:0]   ctrl_out,
    input  logic [DATA_W-1:0]            rx_data,
    input  logic                         rx_empty,
    output logic                         rx_pop,
    output logic [DATA_W-1:0]            tx_wdata,
    input  logic                         tx_full,
    output logic                         tx_push
);

    localparam int BYTES = DATA_W / 8;

    state_t              state;
    state_t              state_nx;
    region_t             dec_region;
    region_t             region_q;
    logic [ADDR_W-1:0]   dec_idx;
    logic [ADDR_W-1:0]   idx_q;
    logic [BYTES-1:0]    dec_mask;
    logic [BYTES-1:0]    mask_q;
    logic                dec_err;
    logic                hwrite_q;
    logic                accept;
    logic                fifo_ok;
    logic                ctrl_we;
    logic [DATA_W-1:0]   reg_rd;
    logic [DATA_W-1:0]   ctrl_q [NUM_CTRL];

`ifdef AHB_USB_RD_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    logic [CNT_W-1:0]    wait_cnt;
`else
    localparam int unused_max_wait = MAX_WAIT;
`endif

    ahb_usb_addr_decode #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_STAT (NUM_STAT),
        .NUM_CTRL (NUM_CTRL)
    ) u_decode (
        .haddr     (haddr),
        .hsize     (hsize),
        .hwrite    (hwrite),
        .region    (dec_region),
        .word_idx  (dec_idx),
        .lane_mask (dec_mask),
        .err       (dec_err)
    );

    // Handshake: an address phase is taken on a clock edge where hsel=1,
    // htrans is NONSEQ/SEQ and hready=1; the data phase of that transfer ends
    // on the first later edge with hready=1, when hrdata/hresp are valid.
    always_comb begin
        reg_rd = '0;
        for (int k = 0; k < NUM_STAT; k++)
            if (idx_q == ADDR_W'(k))
                reg_rd = stat_in[k*DATA_W +: DATA_W];
        for (int k = 0; k < NUM_CTRL; k++)
            if (idx_q == ADDR_W'(NUM_STAT + k))
                reg_rd = ctrl_q[k];
    end

    always_comb begin
        state_nx = state;
        hready   = 1'b1;
        hresp    = 1'b0;
        hrdata   = '0;
        rx_pop   = 1'b0;
        tx_push  = 1'b0;
        tx_wdata = '0;
        ctrl_we  = 1'b0;
        accept   = 1'b0;
        fifo_ok  = hwrite_q ? !tx_full : !rx_empty;

        case (state)
            ST_IDLE: begin
            end
            ST_DATA, ST_WAIT: begin
                if (region_q == REG_DATA) begin
                    if (!fifo_ok) begin
                        hready   = 1'b0;
                        state_nx = ST_WAIT;
`ifdef AHB_USB_RD_TIMEOUT_EN
                        if (state == ST_WAIT && wait_cnt >= CNT_W'(MAX_WAIT - 1))
                            state_nx = ST_ERR1;
`endif
                    end else if (hwrite_q) begin
                        tx_push  = 1'b1;
                        tx_wdata = hwdata;
                    end else begin
                        rx_pop = 1'b1;
                        hrdata = rx_data;
                    end
                end else begin
                    if (!hwrite_q)
                        hrdata = reg_rd;
                    ctrl_we = hwrite_q && (region_q == REG_CTRL);
                end
            end
            ST_ERR1: begin
                hresp    = 1'b1;
                hready   = 1'b0;
                state_nx = ST_ERR2;
            end
            ST_ERR2: begin
                hresp = 1'b1;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Any cycle that completes a data phase can also take the next address phase.
        accept = hready && hsel && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
        if (hready)
            state_nx = accept ? (dec_err ? ST_ERR1 : ST_DATA) : ST_IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= ST_IDLE;
            region_q <= REG_BAD;
            idx_q    <= '0;
            mask_q   <= '0;
            hwrite_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                region_q <= dec_region;
                idx_q    <= dec_idx;
                mask_q   <= dec_mask;
                hwrite_q <= hwrite;
            end
        end
    end

`ifdef AHB_USB_RD_TIMEOUT_EN
    // Counts stalled cycles already spent, including the first one in ST_DATA.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            wait_cnt <= '0;
        else if (state_nx == ST_WAIT)
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : CNT_W'(1);
        else
            wait_cnt <= '0;
    end
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < NUM_CTRL; k++)
                ctrl_q[k] <= '0;
        end else if (ctrl_we) begin
            for (int k = 0; k < NUM_CTRL; k++)
                if (idx_q == ADDR_W'(NUM_STAT + k))
                    for (int b = 0; b < BYTES; b++)
                        if (mask_q[b])
                            ctrl_q[k][8*b +: 8] <= hwdata[8*b +: 8];
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CTRL; k++)
            ctrl_out[k*DATA_W +: DATA_W] = ctrl_q[k];
    end

endmodule
